pam4_level_tx: RTL
==================

# pam4_level_tx

Byte-to-PAM4 symbol transmitter for the Tx simulation path. It accepts bytes over a valid/ready handshake and splits each byte into four 2-bit symbols. Each symbol is mapped to one of the four signed 8-bit voltage levels (−84, −28, +28, +84) and emitted on the `voltage_level`/`voltage_valid` interface at a programmable symbol rate. It is the producer for the level-display and channel blocks downstream.

## Interface
Parameters:
- `SYM_DIV`, default 4: clock cycles per symbol; legal range 1..255.
- `MSB_FIRST`, default 1: 1 sends bits [7:6] first; 0 sends bits [1:0] first.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `data_in`  in  8  byte to transmit.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  the block accepts `data_in` on this edge. Combinational from state.
- `voltage_level`  out  8  two's-complement level of the current symbol (registered).
- `voltage_valid`  out  1  one-cycle pulse marking a new symbol (registered).
- `busy`  out  1  high while in SEND.
- `sym_count`  out  16  total symbols emitted; wraps 0xFFFF→0x0000.

## Operation
- States: IDLE and SEND. Internal state:
  - 8-bit shift register.
  - `sym_idx` (0..3).
  - `div_cnt` (0..SYM_DIV−1).
- Accept condition: `data_valid && data_ready` at a rising edge.
- `data_ready` is high in these cases, and low otherwise:
  - the block is in IDLE;
  - the block is in SEND with `sym_idx==3 && div_cnt==SYM_DIV−1` (back-to-back).
- On accept:
  - load the shift register;
  - `sym_idx←0`, `div_cnt←0`, state←SEND;
  - `voltage_level←map(first symbol)`, `voltage_valid←1`, `sym_count←sym_count+1`.
- In SEND, each cycle:
  - If `div_cnt<SYM_DIV−1`: `div_cnt++` and `voltage_valid←0`.
  - Else, if `sym_idx<3`: `div_cnt←0`, `sym_idx++`, emit the next symbol (level, valid pulse, count++).
  - Else, if `sym_idx==3`: accept a new byte if offered; otherwise go to IDLE with `voltage_valid←0`.
- `voltage_level` holds its last value between pulses and in IDLE.
- Level encoding:
  - −84 = 0xAC
  - −28 = 0xE4
  - +28 = 0x1C
  - +84 = 0x54
- Symbol-to-level mapping (see Configuration): 2-bit symbol `s` → level.
- `data_in` is ignored when `data_ready` is low. A producer holding `data_valid` simply waits.

## Timing
- Reset values (asynchronous, while `rstn`=0):
  - state IDLE, `busy`=0, `voltage_level`=0x00, `voltage_valid`=0, `sym_count`=0.
  - `data_ready`=0 while in reset, and 1 from the first cycle after release.
- Latency: the first symbol of a byte is visible one cycle after the accept edge E0.
- Symbol k (k=0..3) has its `voltage_valid` pulse registered at edge E0+k·SYM_DIV.
- Next-byte accept edge for continuous streaming: E0+4·SYM_DIV. Gapless streaming yields one pulse every SYM_DIV cycles.
- `SYM_DIV=1`: `voltage_valid` stays high continuously while streaming; a new level appears every cycle.
- Reset mid-byte: the remaining symbols are discarded. After release the block is in IDLE with no pulse.
- `sym_count` wraps silently, with no flag.

## Configuration
- `PAM4_GRAY_EN` defined: Gray mapping.
  - 00→−84, 01→−28, 11→+28, 10→+84.
  - Adjacent levels differ by one bit.
- `PAM4_GRAY_EN` undefined: natural binary mapping.
  - 00→−84, 01→−28, 10→+28, 11→+84.

## Test plan
- Reset check: assert `rstn`=0 mid-stream, then release.
  - While in reset: all outputs match the reset values; `data_ready`=0.
  - After release: `data_ready`=1 and `busy`=0.
- Single byte, Gray, SYM_DIV=4, MSB_FIRST=1: send 0x1B.
  - Pulses at E0, E0+4, E0+8, E0+12.
  - Levels 0xAC, 0xE4, 0x54, 0x1C.
  - `sym_count`=4; IDLE at E0+16.
- Binary mapping (macro undefined), MSB_FIRST=0: send 0x1B.
  - Symbols 11, 10, 01, 00.
  - Levels 0x54, 0x1C, 0xE4, 0xAC.
- Back-to-back, SYM_DIV=1: hold `data_valid`=1 with bytes 0x00 then 0xFF.
  - Eight consecutive cycles of `voltage_valid`=1.
  - Levels 0xAC×4, then the level for 11 (Gray 0x1C / binary 0x54) ×4.
  - `data_ready` high only on accept cycles.
- Backpressure: assert `data_valid` with 0xAA during symbol 1 of a prior byte.
  - The byte is not accepted until E0+4·SYM_DIV.
  - No symbol is lost or duplicated.
- Wrap: preload via 16384 bytes.
  - `sym_count` reads 0x0000 after the 65536th symbol.

Source files
------------

// File: rtl/pam4_level_tx.sv
// Byte-to-PAM4 transmitter: splits each accepted byte into four 2-bit symbols, one per SYM_DIV cycles.
// Define PAM4_GRAY_EN for Gray symbol mapping; natural binary mapping otherwise.
module pam4_level_tx #(
    parameter int unsigned SYM_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [7:0]  i_data_in,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    output logic [7:0]  o_voltage_level,
    output logic        o_voltage_valid,
    output logic        o_busy,
    output logic [15:0] o_sym_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;
    localparam logic [7:0] DIV_LAST = 8'(SYM_DIV - 1);

    localparam logic [7:0] LVL_N84 = 8'hAC;
    localparam logic [7:0] LVL_N28 = 8'hE4;
    localparam logic [7:0] LVL_P28 = 8'h1C;
    localparam logic [7:0] LVL_P84 = 8'h54;

    logic [0:0]  r_state;
    logic [7:0]  r_shift;
    logic [1:0]  r_sym_idx;
    logic [7:0]  r_div_cnt;
    logic [7:0]  r_level;
    logic        r_valid;
    logic [15:0] r_count;
    logic        r_out_en;

    logic [0:0]  w_state_nxt;
    logic [7:0]  w_shift_nxt;
    logic [1:0]  w_idx_nxt;
    logic [7:0]  w_div_nxt;
    logic [7:0]  w_level_nxt;
    logic        w_valid_nxt;
    logic [15:0] w_count_nxt;
    logic        w_sym_end;
    logic        w_last_slot;
    logic        w_accept;

    function automatic logic [7:0] pam4_map(input logic [1:0] sym);
        logic [7:0] lvl;
`ifdef PAM4_GRAY_EN
        case (sym)
            2'b00:   lvl = LVL_N84;
            2'b01:   lvl = LVL_N28;
            2'b11:   lvl = LVL_P28;
            default: lvl = LVL_P84;
        endcase
`else
        case (sym)
            2'b00:   lvl = LVL_N84;
            2'b01:   lvl = LVL_N28;
            2'b10:   lvl = LVL_P28;
            default: lvl = LVL_P84;
        endcase
`endif
        return lvl;
    endfunction

    function automatic logic [1:0] head_sym(input logic [7:0] b);
        return MSB_FIRST ? b[7:6] : b[1:0];
    endfunction

    // Drop the symbol just emitted so the next one sits at the head.
    function automatic logic [7:0] drop_sym(input logic [7:0] b);
        return MSB_FIRST ? {b[5:0], 2'b00} : {2'b00, b[7:2]};
    endfunction

    assign w_sym_end   = (r_div_cnt == DIV_LAST);
    assign w_last_slot = (r_state == ST_SEND) && (r_sym_idx == 2'd3) && w_sym_end;
    // r_out_en keeps ready low while reset is asserted and until the first edge after release.
    assign o_data_ready = r_out_en && ((r_state == ST_IDLE) || w_last_slot);
    assign w_accept     = i_data_valid && o_data_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_sym_idx;
        w_div_nxt   = r_div_cnt;
        w_level_nxt = r_level;
        w_valid_nxt = 1'b0;
        w_count_nxt = r_count;
        if (w_accept) begin
            w_state_nxt = ST_SEND;
            w_shift_nxt = drop_sym(i_data_in);
            w_idx_nxt   = 2'd0;
            w_div_nxt   = 8'd0;
            w_level_nxt = pam4_map(head_sym(i_data_in));
            w_valid_nxt = 1'b1;
            w_count_nxt = r_count + 16'd1;
        end else if (r_state == ST_SEND) begin
            if (!w_sym_end) begin
                w_div_nxt = r_div_cnt + 8'd1;
            end else if (r_sym_idx != 2'd3) begin
                w_div_nxt   = 8'd0;
                w_idx_nxt   = r_sym_idx + 2'd1;
                w_level_nxt = pam4_map(head_sym(r_shift));
                w_valid_nxt = 1'b1;
                w_count_nxt = r_count + 16'd1;
                w_shift_nxt = drop_sym(r_shift);
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'd0;
            r_sym_idx <= 2'd0;
            r_div_cnt <= 8'd0;
            r_level   <= 8'd0;
            r_valid   <= 1'b0;
            r_count   <= 16'd0;
            r_out_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_sym_idx <= w_idx_nxt;
            r_div_cnt <= w_div_nxt;
            r_level   <= w_level_nxt;
            r_valid   <= w_valid_nxt;
            r_count   <= w_count_nxt;
            r_out_en  <= 1'b1;
        end
    end

    assign o_voltage_level = r_level;
    assign o_voltage_valid = r_valid;
    assign o_busy          = (r_state == ST_SEND);
    assign o_sym_count     = r_count;

endmodule
